pc_sequencer: RTL and testbench

Program-counter sequencer that drives `pc_out` into the registered branch-target adder and consumes that adder's result one or more cycles later. It holds the PC steady while the target settles, then redirects fetch, or falls through by +4. It also flags misaligned targets and redirects them to a trap vector. It sits at the front of the fetch stage, ahead of instruction memory.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_sequencer_pc_next_sel.sv | 28 ++
 rtl/pc_sequencer.sv | 90 +++++++++
 tb/tb_pc_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} pc_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_PLUS4  = 2'd1,
    SEL_TARGET = 2'd2
  } pc_sel_t;

  localparam int unsigned INSN_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_sequencer_pc_next_sel.sv
// Combinational next-PC mux: hold, +4, or target. A misaligned target becomes the trap vector.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int unsigned    WIDTH   = 32,
  parameter logic [WIDTH-1:0] TRAP_PC = 32'h0000_0100
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] target,
  input  pc_sel_t          sel,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             tgt_misaligned
);

  assign pc_plus4       = pc + WIDTH'(INSN_BYTES);
  assign tgt_misaligned = |(target[1:0] & ALIGN_MASK);

  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_PLUS4:  pc_next = pc_plus4;
      SEL_TARGET: pc_next = tgt_misaligned ? TRAP_PC : target;
      default:    pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: holds the PC while the registered branch-target adder settles, then redirects.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_PC     = 32'h0000_0100,
  parameter int unsigned      TGT_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_req,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] target_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             busy,
  output logic             misaligned
);

  localparam int unsigned CW = $clog2(TGT_LATENCY + 1);

  pc_state_t        state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic             mis_q, mis_n;
  logic             tgt_mis;
  pc_sel_t          sel;

  pc_next_sel #(.WIDTH(WIDTH), .TRAP_PC(TRAP_PC)) u_sel (
    .pc             (pc_q),
    .target         (target_in),
    .sel            (sel),
    .pc_next        (pc_n),
    .pc_plus4       (pc_plus4),
    .tgt_misaligned (tgt_mis)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel     = SEL_HOLD;
    mis_n   = 1'b0;
    case (state)
      RUN: begin
        if (branch_req && branch_taken) begin
          state_n = WAIT;
          cnt_n   = CW'(TGT_LATENCY);
        end else begin
          sel = SEL_PLUS4;
        end
      end
      WAIT: begin
        // branch_req is ignored here: decode is flushed while the target settles
        if (cnt == CW'(1)) begin
          sel     = SEL_TARGET;
          state_n = RUN;
          cnt_n   = '0;
          mis_n   = tgt_mis;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else if (!stall) begin
      state <= state_n;
      cnt   <= cnt_n;
      pc_q  <= pc_n;
      mis_q <= mis_n;
    end
  end

  assign pc_out      = pc_q;
  assign busy        = (state == WAIT);
  assign misaligned  = mis_q;
  // Gated by reset so the first fetch at RESET_PC is valid as soon as reset drops.
  assign fetch_valid = (state == RUN) && !reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default-latency instance plus a TGT_LATENCY=3 instance.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance
  logic        reset = 1'b1, stall = 1'b0, branch_req = 1'b0, branch_taken = 1'b0;
  logic [31:0] target_in = '0;
  logic [31:0] pc_out, pc_plus4;
  logic        fetch_valid, busy, misaligned;

  // latency-3 instance
  logic        reset3 = 1'b1, stall3 = 1'b0, br3 = 1'b0, tk3 = 1'b0;
  logic [31:0] tgt3 = '0;
  logic [31:0] pc3, pc3_plus4;
  logic        fv3, busy3, mis3;

  int checks = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_req(branch_req),
    .branch_taken(branch_taken), .target_in(target_in), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .busy(busy), .misaligned(misaligned)
  );

  pc_sequencer #(.TGT_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .stall(stall3), .branch_req(br3),
    .branch_taken(tk3), .target_in(tgt3), .pc_out(pc3),
    .pc_plus4(pc3_plus4), .fetch_valid(fv3), .busy(busy3), .misaligned(mis3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    reset = 1'b0; #1;
    chk("post_rst_fv", {31'b0, fetch_valid}, 32'd1);
    chk("post_rst_pc", pc_out, 32'h0);

    // free run
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("seq_pc", pc_out, 32'(i * 4));
      chk("seq_busy", {31'b0, busy}, 32'd0);
    end

    // taken branch at 0x20, aligned target
    branch_req = 1'b1; branch_taken = 1'b1;
    step();
    chk("tk_hold_pc", pc_out, 32'h20);
    chk("tk_busy", {31'b0, busy}, 32'd1);
    chk("tk_fv", {31'b0, fetch_valid}, 32'd0);
    branch_req = 1'b0; branch_taken = 1'b0; target_in = 32'h40;
    step();
    chk("tk_redir_pc", pc_out, 32'h40);
    chk("tk_redir_fv", {31'b0, fetch_valid}, 32'd1);
    chk("tk_redir_busy", {31'b0, busy}, 32'd0);
    step();
    chk("tk_next_pc", pc_out, 32'h44);

    // not-taken branch: no bubble
    branch_req = 1'b1; branch_taken = 1'b0;
    step();
    chk("nt_pc", pc_out, 32'h48);
    chk("nt_busy", {31'b0, busy}, 32'd0);

    // stall in RUN holds PC
    branch_req = 1'b0; stall = 1'b1;
    step();
    chk("stall_run_pc", pc_out, 32'h48);
    stall = 1'b0;

    // misaligned target -> trap
    branch_req = 1'b1; branch_taken = 1'b1;
    step();
    chk("mis_wait_pc", pc_out, 32'h48);
    branch_req = 1'b0; branch_taken = 1'b0; target_in = 32'h42;
    step();
    chk("mis_trap_pc", pc_out, 32'h100);
    chk("mis_pulse", {31'b0, misaligned}, 32'd1);
    step();
    chk("mis_after_pc", pc_out, 32'h104);
    chk("mis_clear", {31'b0, misaligned}, 32'd0);

    // reset during WAIT drops the pending target
    branch_req = 1'b1; branch_taken = 1'b1;
    step();
    chk("rw_busy", {31'b0, busy}, 32'd1);
    branch_req = 1'b0; branch_taken = 1'b0; target_in = 32'h200; reset = 1'b1;
    step();
    chk("rw_pc", pc_out, 32'h0);
    chk("rw_busy0", {31'b0, busy}, 32'd0);
    chk("rw_fv", {31'b0, fetch_valid}, 32'd0);
    reset = 1'b0;
    step();
    chk("rw_after_pc", pc_out, 32'h4);

    // wrap from 0xFFFF_FFFC
    branch_req = 1'b1; branch_taken = 1'b1;
    step();
    branch_req = 1'b0; branch_taken = 1'b0; target_in = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step();
    chk("wrap_next", pc_out, 32'h0);

    // latency 3 with 2 stall cycles inside WAIT
    reset3 = 1'b0; tgt3 = 32'h80;
    step(); step();
    chk("l3_pc8", pc3, 32'h8);
    br3 = 1'b1; tk3 = 1'b1;
    step();
    chk("l3_h1", pc3, 32'h8);
    chk("l3_busy1", {31'b0, busy3}, 32'd1);
    br3 = 1'b0; tk3 = 1'b0;
    step();
    chk("l3_h2", pc3, 32'h8);
    stall3 = 1'b1;
    step();
    chk("l3_h3", pc3, 32'h8);
    step();
    chk("l3_h4", pc3, 32'h8);
    stall3 = 1'b0;
    step();
    chk("l3_h5", pc3, 32'h8);
    chk("l3_busy5", {31'b0, busy3}, 32'd1);
    step();
    chk("l3_redir", pc3, 32'h80);
    chk("l3_fv", {31'b0, fv3}, 32'd1);
    chk("l3_mis", {31'b0, mis3}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
